vend_order_fsm: RTL and testbench
=================================

# vend_order_fsm

Sequential front-end that sits directly upstream of the combinational `vendingmachine` stage. It accumulates inserted coins, latches the customer's product selection, and presents a stable `code`/`count`/`money` triple to that stage. It samples the `posibility`/`remaining` verdict, then runs the dispense handshake and the unit-by-unit change payout.

## Interface
- `TIMEOUT`, default 255: idle cycles in COLLECT before automatic refund.
- `MONEY_MAX`, default 15: saturation limit of the 4-bit credit register.
- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `coin_valid` in 1: one-cycle coin insertion strobe.
- `coin_value` in 4: value of the inserted coin in money units.
- `sel_valid` in 1: one-cycle selection strobe.
- `sel_code` in 2: requested product code.
- `sel_count` in 3: requested quantity.
- `cancel` in 1: customer abort strobe.
- `code` out 2: product code presented to the `vendingmachine` stage.
- `count` out 3: quantity presented to the `vendingmachine` stage.
- `money` out 4: current credit presented to the `vendingmachine` stage.
- `posibility` in 1: verdict from the `vendingmachine` stage.
- `remaining` in 4: change amount from the `vendingmachine` stage.
- `dispense_valid` out 1: dispense request; held until acknowledged.
- `dispense_ack` in 1: acknowledge from the dispensing mechanism.
- `change_pulse` out 1: one pulse per returned money unit.
- `coin_reject` out 1: one-cycle pulse; the coin in that cycle was not credited.
- `deny` out 1: one-cycle pulse; the selection was refused.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, COLLECT, CHECK, DISPENSE, CHANGE.
- IDLE:
  - `money`=0.
  - `coin_valid` credits `coin_value` and moves to COLLECT.
  - `sel_valid` and `cancel` are ignored.
- COLLECT:
  - Priority order: `cancel` > coin > selection.
  - `cancel`: the change counter loads `money` and the FSM moves to CHANGE. A coin in the same cycle is rejected.
  - Coin: `money`+`coin_value` is computed 5 bits wide. If the sum exceeds `MONEY_MAX`, pulse `coin_reject` and leave `money` unchanged. Otherwise credit the coin.
  - Selection: only a `sel_valid` with `sel_count`≠0 is accepted; `sel_count`=0 is ignored. On acceptance, latch `code`/`count` and move to CHECK.
  - A coin and a selection in the same cycle: the coin is credited first, and CHECK uses the updated `money`.
  - Timeout counter: reloads to `TIMEOUT` on any accepted coin or selection. When it reaches 0, the change counter loads `money` and the FSM moves to CHANGE.
- CHECK:
  - Lasts exactly 1 cycle; `code`/`count`/`money` are stable throughout.
  - At the end of the cycle, sample `posibility`.
  - `posibility`=1: the change counter loads `remaining`, `money` clears to 0, and the FSM moves to DISPENSE.
  - `posibility`=0: pulse `deny` and return to COLLECT with `money` kept. The timeout counter reloads.
- DISPENSE:
  - `dispense_valid`=1, with `code`/`count` held.
  - On `dispense_ack` high at a rising edge, move to CHANGE.
  - `cancel` is ignored here.
- CHANGE:
  - While the change counter is >0: `change_pulse`=1 and the counter decrements, one unit per cycle.
  - When the counter is 0: no pulse, move to IDLE.
  - Entering CHANGE with 0 change gives one cycle with no pulse, then IDLE.
- Coins in CHECK, DISPENSE or CHANGE: `coin_reject` pulses and no credit is given.

## Timing
- All outputs are registered.
- Reset values: `code`=0, `count`=0, `money`=0, `dispense_valid`=0, `change_pulse`=0, `coin_reject`=0, `deny`=0, `busy`=0, state=IDLE, timeout counter=`TIMEOUT`.
- `sel_valid` at edge n → state CHECK after edge n. If `posibility`=1, `dispense_valid` is high after edge n+1 (2-cycle latency).
- A refund of N units takes N cycles of `change_pulse`, plus 1 cycle to return to IDLE.
- `coin_reject` and `deny` are asserted in the cycle after the offending edge.
- Asserting `rst_n` low mid-operation forces all reset values immediately. Credit and pending change are discarded; this is accepted behaviour.

## Structure
- Shared package `vend_pkg`:
  - state encoding localparams;
  - `MONEY_W`=4, `CODE_W`=2, `COUNT_W`=3;
  - the default `MONEY_MAX`.
- Sub-module `vend_timeout`: loadable down-counter with `reload`/`enable` inputs and an `expired` output.
- Everything else stays in `vend_order_fsm`.

## Test plan
- Happy path: coins 5, then 5; select code 2, count 1. Model returns `posibility`=1, `remaining`=3. Required: `dispense_valid` 2 cycles after the selection; after ack, exactly 3 `change_pulse`; then IDLE.
- Overflow: credit 12, insert coin 4. Required: `coin_reject` pulse, `money` stays 12. A following coin 3 is accepted, giving 15.
- Deny: model returns `posibility`=0. Required: `deny` pulse, state returns to COLLECT, `money` unchanged. A coin of 2 then gives `money`+2.
- Cancel with a simultaneous coin, credit 7. Required: `coin_reject` pulse, then 7 `change_pulse`, then IDLE.
- Timeout: `TIMEOUT`=8, credit 4, no activity. Required: 4 `change_pulse` starting 8 cycles after the last event.
- Reset asserted in DISPENSE and in CHANGE mid-payout. Required: all outputs immediately at reset values, no further pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending order front-end.
package vend_pkg;

   localparam int unsigned MONEY_W       = 4;
   localparam int unsigned CODE_W        = 2;
   localparam int unsigned COUNT_W       = 3;
   localparam int unsigned MONEY_MAX_DEF = 15;

   // State encoding
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_COLLECT  = 3'd1;
   localparam logic [2:0] S_CHECK    = 3'd2;
   localparam logic [2:0] S_DISPENSE = 3'd3;
   localparam logic [2:0] S_CHANGE   = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = S_IDLE,
      COLLECT  = S_COLLECT,
      CHECK    = S_CHECK,
      DISPENSE = S_DISPENSE,
      CHANGE   = S_CHANGE
   } state_t;

endpackage

// File: rtl/vend_timeout.sv
// Loadable inactivity down-counter. expired flags the edge at which the
// count reaches zero, so the owner can act on that same edge.
module vend_timeout #(
   parameter int unsigned LOAD = 255,
   parameter int unsigned W    = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reload,
   input  logic enable,
   output logic expired
);

   logic [W-1:0] cnt;

   // Count down while enabled; any reload restarts the interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= W'(LOAD);
      end else if (reload) begin
         cnt <= W'(LOAD);
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expired = enable && !reload && (cnt <= W'(1));

endmodule

// File: rtl/vend_order_fsm.sv
// Order front-end: collects coins, latches a selection, consults the
// downstream vendingmachine verdict, then dispenses and pays change.
module vend_order_fsm
   import vend_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned MONEY_MAX = MONEY_MAX_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               coin_valid,
   input  logic [MONEY_W-1:0] coin_value,
   input  logic               sel_valid,
   input  logic [CODE_W-1:0]  sel_code,
   input  logic [COUNT_W-1:0] sel_count,
   input  logic               cancel,
   output logic [CODE_W-1:0]  code,
   output logic [COUNT_W-1:0] count,
   output logic [MONEY_W-1:0] money,
   input  logic               posibility,
   input  logic [MONEY_W-1:0] remaining,
   output logic               dispense_valid,
   input  logic               dispense_ack,
   output logic               change_pulse,
   output logic               coin_reject,
   output logic               deny,
   output logic               busy
);

   localparam int unsigned    TO_W    = $clog2(TIMEOUT + 2);
   localparam logic [MONEY_W:0] MAX_SUM = (MONEY_W + 1)'(MONEY_MAX);

   // Change units still owed after the pulse currently on change_pulse.
   function automatic logic [MONEY_W-1:0] dec_floor(input logic [MONEY_W-1:0] v);
      return (v != '0) ? v - MONEY_W'(1) : '0;
   endfunction

   state_t             state;
   logic [MONEY_W-1:0] chg;
   logic [MONEY_W:0]   sum;
   logic               coin_ok;
   logic               sel_ok;
   logic               coin_acc;
   logic               idle_coin;
   logic               tmo_reload;
   logic               tmo_enable;
   logic               tmo_expired;

   assign sum        = {1'b0, money} + {1'b0, coin_value};
   assign coin_ok    = (sum <= MAX_SUM);
   assign sel_ok     = sel_valid && (sel_count != '0);
   assign coin_acc   = (state == COLLECT) && !cancel && coin_valid && coin_ok;
   assign idle_coin  = (state == IDLE) && coin_valid && coin_ok;
   assign tmo_enable = (state == COLLECT);
   assign tmo_reload = idle_coin || coin_acc
                    || ((state == COLLECT) && !cancel && sel_ok)
                    || ((state == CHECK) && !posibility);

   vend_timeout #(
      .LOAD (TIMEOUT),
      .W    (TO_W)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .reload  (tmo_reload),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   // Order sequencing with all customer-facing outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         chg            <= '0;
         code           <= '0;
         count          <= '0;
         money          <= '0;
         dispense_valid <= 1'b0;
         change_pulse   <= 1'b0;
         coin_reject    <= 1'b0;
         deny           <= 1'b0;
         busy           <= 1'b0;
      end else begin
         coin_reject  <= 1'b0;
         deny         <= 1'b0;
         change_pulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (coin_valid) begin
                  if (coin_ok) begin
                     money <= coin_value;
                     state <= COLLECT;
                     busy  <= 1'b1;
                  end else begin
                     coin_reject <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (cancel) begin
                  coin_reject  <= coin_valid;
                  change_pulse <= (money != '0);
                  chg          <= dec_floor(money);
                  money        <= '0;
                  state        <= CHANGE;
               end else begin
                  if (coin_valid && !coin_ok) coin_reject <= 1'b1;
                  if (coin_acc) money <= sum[MONEY_W-1:0];
                  if (sel_ok) begin
                     code  <= sel_code;
                     count <= sel_count;
                     state <= CHECK;
                  end else if (tmo_expired) begin
                     change_pulse <= (money != '0);
                     chg          <= dec_floor(money);
                     money        <= '0;
                     state        <= CHANGE;
                  end
               end
            end
            CHECK: begin
               coin_reject <= coin_valid;
               if (posibility) begin
                  chg            <= remaining;
                  money          <= '0;
                  dispense_valid <= 1'b1;
                  state          <= DISPENSE;
               end else begin
                  deny  <= 1'b1;
                  state <= COLLECT;
               end
            end
            DISPENSE: begin
               coin_reject <= coin_valid;
               if (dispense_ack) begin
                  dispense_valid <= 1'b0;
                  change_pulse   <= (chg != '0);
                  chg            <= dec_floor(chg);
                  state          <= CHANGE;
               end
            end
            CHANGE: begin
               coin_reject <= coin_valid;
               if (chg != '0) begin
                  change_pulse <= 1'b1;
                  chg          <= chg - MONEY_W'(1);
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_order_fsm.sv
// Scoreboard bench for vend_order_fsm: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_vend_order_fsm;

   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       coin_valid;
   logic [3:0] coin_value;
   logic       sel_valid;
   logic [1:0] sel_code;
   logic [2:0] sel_count;
   logic       cancel;
   logic [1:0] code;
   logic [2:0] count;
   logic [3:0] money;
   logic       posibility;
   logic [3:0] remaining;
   logic       dispense_valid;
   logic       dispense_ack;
   logic       change_pulse;
   logic       coin_reject;
   logic       deny;
   logic       busy;

   always #5 clk = ~clk;

   vend_order_fsm #(.TIMEOUT(TMO), .MONEY_MAX(15)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .coin_valid     (coin_valid),
      .coin_value     (coin_value),
      .sel_valid      (sel_valid),
      .sel_code       (sel_code),
      .sel_count      (sel_count),
      .cancel         (cancel),
      .code           (code),
      .count          (count),
      .money          (money),
      .posibility     (posibility),
      .remaining      (remaining),
      .dispense_valid (dispense_valid),
      .dispense_ack   (dispense_ack),
      .change_pulse   (change_pulse),
      .coin_reject    (coin_reject),
      .deny           (deny),
      .busy           (busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Expected event queues: money at reject/deny, code*8+count at dispense,
   // length of each change_pulse burst.
   int rej_q[$];
   int deny_q[$];
   int disp_q[$];
   int chg_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic score(input int kind, input int act);
      int exp;
      case (kind)
         0: if (rej_q.size() == 0) check("unexpected coin_reject", act, -1);
            else begin exp = rej_q.pop_front(); check("coin_reject money", act, exp); end
         1: if (deny_q.size() == 0) check("unexpected deny", act, -1);
            else begin exp = deny_q.pop_front(); check("deny money", act, exp); end
         2: if (disp_q.size() == 0) check("unexpected dispense", act, -1);
            else begin exp = disp_q.pop_front(); check("dispense code/count", act, exp); end
         default: if (chg_q.size() == 0) check("unexpected change burst", act, -1);
            else begin exp = chg_q.pop_front(); check("change pulse count", act, exp); end
      endcase
   endtask

   // Monitor
   initial begin
      logic disp_d;
      int   run;
      disp_d = 1'b0;
      run    = 0;
      forever begin
         @(negedge clk);
         if (coin_reject) score(0, int'(money));
         if (deny) score(1, int'(money));
         if (dispense_valid && !disp_d) score(2, int'(code) * 8 + int'(count));
         disp_d = dispense_valid;
         if (change_pulse) run++;
         else if (run != 0) begin
            score(3, run);
            run = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input int v);
      coin_valid = 1'b1;
      coin_value = 4'(v);
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic sel(input int c, input int n);
      sel_valid = 1'b1;
      sel_code  = 2'(c);
      sel_count = 3'(n);
      tick();
      sel_valid = 1'b0;
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (busy && k < bound) begin
         tick();
         k++;
      end
      check("return to idle (busy)", int'(busy), 0);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, " code"}, int'(code), 0);
      check({tag, " count"}, int'(count), 0);
      check({tag, " money"}, int'(money), 0);
      check({tag, " dispense_valid"}, int'(dispense_valid), 0);
      check({tag, " change_pulse"}, int'(change_pulse), 0);
      check({tag, " coin_reject"}, int'(coin_reject), 0);
      check({tag, " deny"}, int'(deny), 0);
      check({tag, " busy"}, int'(busy), 0);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      rst_n        = 1'b0;
      coin_valid   = 1'b0;
      coin_value   = '0;
      sel_valid    = 1'b0;
      sel_code     = '0;
      sel_count    = '0;
      cancel       = 1'b0;
      posibility   = 1'b0;
      remaining    = '0;
      dispense_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Happy path: 5+5, select code 2 count 1, change 3
      posibility = 1'b1;
      remaining  = 4'd3;
      coin(5);
      check("first coin money", int'(money), 5);
      check("busy after coin", int'(busy), 1);
      coin(5);
      check("second coin money", int'(money), 10);
      disp_q.push_back(2 * 8 + 1);
      sel(2, 1);
      check("check-state money", int'(money), 10);
      check("check-state dispense_valid", int'(dispense_valid), 0);
      tick();
      check("dispense_valid latency", int'(dispense_valid), 1);
      check("money cleared on accept", int'(money), 0);
      tick();
      check("dispense_valid held", int'(dispense_valid), 1);
      chg_q.push_back(3);
      dispense_ack = 1'b1;
      tick();
      dispense_ack = 1'b0;
      check("dispense_valid dropped", int'(dispense_valid), 0);
      repeat (3) tick();
      check("happy idle busy", int'(busy), 0);
      check("happy idle pulse", int'(change_pulse), 0);

      // Overflow: 12 + 4 rejected, then + 3 accepted
      coin(12);
      check("overflow base money", int'(money), 12);
      rej_q.push_back(12);
      coin(4);
      check("overflow coin_reject", int'(coin_reject), 1);
      check("overflow money kept", int'(money), 12);
      coin(3);
      check("fill to max money", int'(money), 15);
      chg_q.push_back(15);
      do_cancel();
      wait_idle(40);

      // Deny, then further credit, then count-0 selection ignored
      posibility = 1'b0;
      coin(6);
      deny_q.push_back(6);
      sel(1, 2);
      check("deny latched code", int'(code), 1);
      check("deny latched count", int'(count), 2);
      tick();
      check("deny pulse", int'(deny), 1);
      check("deny money kept", int'(money), 6);
      check("deny busy", int'(busy), 1);
      coin(2);
      check("coin after deny", int'(money), 8);
      posibility = 1'b1;
      remaining  = 4'd0;
      sel(1, 0);
      tick();
      check("count-0 selection ignored", int'(dispense_valid), 0);
      chg_q.push_back(8);
      do_cancel();
      wait_idle(40);

      // Cancel with simultaneous coin, credit 7
      posibility = 1'b0;
      coin(7);
      rej_q.push_back(0);
      chg_q.push_back(7);
      cancel     = 1'b1;
      coin_valid = 1'b1;
      coin_value = 4'd3;
      tick();
      cancel     = 1'b0;
      coin_valid = 1'b0;
      check("cancel coin_reject", int'(coin_reject), 1);
      wait_idle(40);

      // Timeout refund of 4
      coin(4);
      chg_q.push_back(4);
      k = 0;
      while (k < 30) begin
         tick();
         k++;
         if (change_pulse) break;
      end
      check("timeout first pulse delay", k, TMO);
      wait_idle(40);

      // Reset while in DISPENSE
      posibility = 1'b1;
      remaining  = 4'd5;
      coin(9);
      disp_q.push_back(3 * 8 + 4);
      sel(3, 4);
      tick();
      check("dispense before reset", int'(dispense_valid), 1);
      rej_q.push_back(0);
      coin(1);
      check("coin rejected in dispense", int'(coin_reject), 1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_outs("reset in dispense");
      release_reset();
      repeat (6) tick();
      check("no pulse after dispense reset", int'(change_pulse), 0);
      check("idle after dispense reset", int'(busy), 0);

      // Reset mid-payout after 2 of 6 pulses
      coin(6);
      chg_q.push_back(2);
      do_cancel();
      tick();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_outs("reset in change");
      release_reset();
      repeat (8) tick();
      check("no pulse after change reset", int'(change_pulse), 0);

      check("pending rejects", rej_q.size(), 0);
      check("pending denies", deny_q.size(), 0);
      check("pending dispenses", disp_q.size(), 0);
      check("pending change bursts", chg_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
